mont_mul_seq: RTL and testbench

MONT_MUL_SEQ -- requirements
Module: mont_mul_seq

---
 rtl/mont_pkg.sv | 17 +
 rtl/mont_step.sv | 27 ++
 rtl/mont_mul_seq.sv | 124 ++++++++++++
 tb/tb_mont_mul_seq.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mont_pkg.sv
// Shared definitions for the sequential Montgomery multiplier/reducer.
// Holds the FSM state type, mode encodings and the default operand width.
package mont_pkg;

  localparam int DEFAULT_WIDTH = 32;

  localparam logic MODE_MUL  = 1'b0;
  localparam logic MODE_REDC = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } mont_state_e;

endpackage

// File: rtl/mont_step.sv
// One radix-2 Montgomery iteration: optional add of b, add m when odd, halve.
// Purely combinational; the accumulator register lives in mont_mul_seq.
module mont_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH:0]   s_in,
  input  logic               add_b,
  input  logic [WIDTH-1:0]   b,
  input  logic [WIDTH-1:0]   m,
  output logic [2*WIDTH:0]   s_out
);

  logic [2*WIDTH+1:0] sum_b;
  logic [2*WIDTH+1:0] sum_m;

  // One spare bit above the accumulator keeps the additions overflow-free.
  always_comb begin
    sum_b = {1'b0, s_in};
    if (add_b)
      sum_b = sum_b + {{(WIDTH+2){1'b0}}, b};
    sum_m = sum_b;
    if (sum_b[0])
      sum_m = sum_b + {{(WIDTH+2){1'b0}}, m};
    s_out = (2*WIDTH+1)'(sum_m >> 1);
  end

endmodule

// File: rtl/mont_mul_seq.sv
// Sequential bit-serial Montgomery multiply (a*b*R^-1 mod m) and REDC (x*R^-1 mod m).
// One iteration per clock for n cycles, then a single conditional-subtract cycle.
module mont_mul_seq
  import mont_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int NW    = $clog2(WIDTH+1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 mode,
  input  logic [2*WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]     b,
  input  logic [WIDTH-1:0]     m,
  input  logic [NW-1:0]        n,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     result,
  output logic                 err
);

  mont_state_e state, state_next;

  logic                mode_q;
  logic [WIDTH-1:0]    a_sh;
  logic [WIDTH-1:0]    b_q;
  logic [WIDTH-1:0]    m_q;
  logic [NW-1:0]       n_q;
  logic [NW-1:0]       bit_cnt;
  logic [2*WIDTH:0]    acc;
  logic [2*WIDTH:0]    acc_step;
  logic [2*WIDTH:0]    m_ext;
  logic [WIDTH-1:0]    reduced;
  logic [WIDTH-1:0]    result_q;
  logic                err_q;
  logic                req_legal;
  logic                last_bit;

  assign req_legal = m[0] && (n != '0) && (n <= NW'(WIDTH));
  assign last_bit  = (bit_cnt == n_q - NW'(1));
  assign m_ext     = {{(WIDTH+1){1'b0}}, m_q};
  assign reduced   = (acc >= m_ext) ? WIDTH'(acc - m_ext) : acc[WIDTH-1:0];

  mont_step #(.WIDTH(WIDTH)) u_step (
    .s_in  (acc),
    .add_b ((mode_q == MODE_MUL) && a_sh[0]),
    .b     (b_q),
    .m     (m_q),
    .s_out (acc_step)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (in_valid) state_next = req_legal ? RUN : DONE;
      RUN:     if (last_bit) state_next = FINAL;
      FINAL:   state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Operands are latched on accept so the caller may change its inputs immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q   <= MODE_MUL;
      a_sh     <= '0;
      b_q      <= '0;
      m_q      <= '0;
      n_q      <= '0;
      bit_cnt  <= '0;
      acc      <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            mode_q   <= mode;
            a_sh     <= a[WIDTH-1:0];
            b_q      <= b;
            m_q      <= m;
            n_q      <= n;
            bit_cnt  <= '0;
            acc      <= (mode == MODE_REDC) ? {1'b0, a} : '0;
            result_q <= '0;
            err_q    <= !req_legal;
          end
        end
        RUN: begin
          acc     <= acc_step;
          a_sh    <= a_sh >> 1;
          bit_cnt <= bit_cnt + NW'(1);
        end
        FINAL: begin
          result_q <= reduced;
        end
        DONE: begin
          if (out_ready)
            err_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign result = result_q;
  assign err    = err_q;

endmodule

// File: tb/tb_mont_mul_seq.sv
// Self-checking bench for mont_mul_seq: directed cases on a 32-bit instance,
// randomized MUL/REDC on a 64-bit instance against a modular-arithmetic model.
module tb_mont_mul_seq;
  import mont_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          use64;
  logic          in_valid;
  logic          out_ready;
  logic          mode;
  logic [127:0]  a_bus;
  logic [63:0]   b_bus;
  logic [63:0]   m_bus;
  logic [6:0]    n_bus;

  logic          in_ready32, out_valid32, err32;
  logic [31:0]   result32;
  logic          in_ready64, out_valid64, err64;
  logic [63:0]   result64;

  int n_cmp  = 0;
  int n_fail = 0;

  mont_mul_seq #(.WIDTH(32)) dut32 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid & ~use64),
    .in_ready  (in_ready32),
    .mode      (mode),
    .a         (a_bus[63:0]),
    .b         (b_bus[31:0]),
    .m         (m_bus[31:0]),
    .n         (n_bus[5:0]),
    .out_valid (out_valid32),
    .out_ready (out_ready & ~use64),
    .result    (result32),
    .err       (err32)
  );

  mont_mul_seq #(.WIDTH(64)) dut64 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid & use64),
    .in_ready  (in_ready64),
    .mode      (mode),
    .a         (a_bus),
    .b         (b_bus),
    .m         (m_bus),
    .n         (n_bus),
    .out_valid (out_valid64),
    .out_ready (out_ready & use64),
    .result    (result64),
    .err       (err64)
  );

  logic        cur_in_ready, cur_out_valid, cur_err;
  logic [63:0] cur_result;
  assign cur_in_ready  = use64 ? in_ready64  : in_ready32;
  assign cur_out_valid = use64 ? out_valid64 : out_valid32;
  assign cur_err       = use64 ? err64       : err32;
  assign cur_result    = use64 ? result64    : {32'd0, result32};

  // Montgomery result is the unique r < m with r * 2^n == value (mod m).
  function automatic logic [63:0] refMont(input logic is_redc, input logic [127:0] x,
                                          input logic [63:0] bv, input logic [63:0] mv,
                                          input int nv);
    logic [255:0] md, inv2, rinv, v;
    md   = 256'(mv);
    inv2 = (md + 256'd1) >> 1;
    rinv = 256'd1;
    for (int i = 0; i < nv; i++)
      rinv = (rinv * inv2) % md;
    if (is_redc)
      v = 256'(x) % md;
    else
      v = (256'(x[63:0]) * 256'(bv)) % md;
    v = (v * rinv) % md;
    return v[63:0];
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    n_cmp++;
    assert (observed === expected) else begin
      n_fail++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      $error("[TB] %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Presents a request, waits for accept, then counts edges until out_valid.
  task automatic applyStimulus(input logic wide, input logic md, input logic [127:0] av,
                               input logic [63:0] bv, input logic [63:0] mv,
                               input int nv, output int lat);
    int waitc;
    use64    = wide;
    mode     = md;
    a_bus    = av;
    b_bus    = bv;
    m_bus    = mv;
    n_bus    = 7'(nv);
    in_valid = 1'b1;
    waitc    = 0;
    while (!cur_in_ready && waitc < 200) begin
      @(posedge clk); #1;
      waitc++;
    end
    checkOutput("accept_ready", 64'(cur_in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    mode     = ~md;
    a_bus    = {$urandom, $urandom, $urandom, $urandom};
    b_bus    = {$urandom, $urandom};
    m_bus    = {$urandom, $urandom};
    n_bus    = 7'($urandom);
    lat = 1;
    while (!cur_out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic runOp(input string tag, input logic wide, input logic md,
                       input logic [127:0] av, input logic [63:0] bv, input logic [63:0] mv,
                       input int nv, input logic [63:0] exp_res, input logic exp_err,
                       input int exp_lat);
    int lat;
    applyStimulus(wide, md, av, bv, mv, nv, lat);
    checkOutput({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    checkOutput({tag, "_result"}, cur_result, exp_res);
    checkOutput({tag, "_err"}, 64'(cur_err), 64'(exp_err));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput({tag, "_ready_after"}, 64'(cur_in_ready), 64'd1);
    checkOutput({tag, "_valid_after"}, 64'(cur_out_valid), 64'd0);
  endtask

  initial begin
    int          lat;
    logic [63:0] rm, ra, rb, exp_r;
    logic [127:0] rx;
    logic        rmode;

    rst_n     = 1'b0;
    use64     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    mode      = MODE_MUL;
    a_bus     = '0;
    b_bus     = '0;
    m_bus     = '0;
    n_bus     = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] reset state");
    checkOutput("rst_in_ready32", 64'(in_ready32), 64'd1);
    checkOutput("rst_out_valid32", 64'(out_valid32), 64'd0);
    checkOutput("rst_err32", 64'(err32), 64'd0);
    checkOutput("rst_result32", 64'(result32), 64'd0);
    checkOutput("rst_in_ready64", 64'(in_ready64), 64'd1);
    checkOutput("rst_out_valid64", 64'(out_valid64), 64'd0);

    $display("[TB] directed cases, WIDTH=32");
    runOp("mul_13_4",    1'b0, MODE_MUL,  128'd5,   64'd7, 64'd13, 4,  64'd3, 1'b0, 6);
    runOp("redc_100",    1'b0, MODE_REDC, 128'd100, 64'd0, 64'd13, 4,  64'd3, 1'b0, 6);
    runOp("redc_0",      1'b0, MODE_REDC, 128'd0,   64'd0, 64'd13, 4,  64'd0, 1'b0, 6);
    runOp("rej_even",    1'b0, MODE_MUL,  128'd5,   64'd7, 64'd12, 4,  64'd0, 1'b1, 1);
    runOp("rej_n0",      1'b0, MODE_MUL,  128'd5,   64'd7, 64'd13, 0,  64'd0, 1'b1, 1);
    runOp("rej_nbig",    1'b0, MODE_MUL,  128'd5,   64'd7, 64'd13, 33, 64'd0, 1'b1, 1);
    runOp("mul_full32",  1'b0, MODE_MUL,  128'd123456789, 64'd987654321, 64'hFFFF_FFFB, 32,
          refMont(1'b0, 128'd123456789, 64'd987654321, 64'hFFFF_FFFB, 32), 1'b0, 34);

    $display("[TB] output stall with competing request");
    applyStimulus(1'b0, MODE_MUL, 128'd5, 64'd7, 64'd13, 4, lat);
    checkOutput("stall_latency", 64'(lat), 64'd6);
    mode     = MODE_REDC;
    a_bus    = 128'd0;
    m_bus    = 64'd13;
    n_bus    = 7'd4;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checkOutput("stall_result", cur_result, 64'd3);
      checkOutput("stall_in_ready", 64'(cur_in_ready), 64'd0);
      checkOutput("stall_out_valid", 64'(cur_out_valid), 64'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput("handshake_no_accept", 64'(cur_in_ready), 64'd1);
    checkOutput("handshake_valid_low", 64'(cur_out_valid), 64'd0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    checkOutput("idle_after_handshake", 64'(cur_in_ready), 64'd1);

    $display("[TB] reset during RUN");
    use64    = 1'b0;
    mode     = MODE_MUL;
    a_bus    = 128'd5;
    b_bus    = 64'd7;
    m_bus    = 64'd13;
    n_bus    = 7'd4;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    checkOutput("busy_in_run", 64'(cur_in_ready), 64'd0);
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checkOutput("abort_out_valid", 64'(cur_out_valid), 64'd0);
      checkOutput("abort_in_ready", 64'(cur_in_ready), 64'd1);
    end
    runOp("post_reset_mul", 1'b0, MODE_MUL, 128'd5, 64'd7, 64'd13, 4, 64'd3, 1'b0, 6);

    $display("[TB] random MUL/REDC, WIDTH=64, n=64");
    for (int k = 0; k < 600; k++) begin
      rm    = {$urandom, $urandom} | 64'd1;
      ra    = {$urandom, $urandom} % rm;
      rb    = {$urandom, $urandom} % rm;
      rmode = 1'($urandom);
      if (rmode == MODE_REDC)
        rx = {{$urandom, $urandom} % rm, $urandom, $urandom};
      else
        rx = {64'd0, ra};
      exp_r = refMont(rmode, rx, rb, rm, 64);
      runOp(rmode ? "rand_redc" : "rand_mul", 1'b1, rmode, rx, rb, rm, 64, exp_r, 1'b0, 66);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
